// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lock_pkg
// Description : Shared states, key codes and helpers for the lock controller.
// Revision    : 1.0 - initial release
// ============================================================================
package lock_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [3:0] KEY_CONFIRM = 4'hA;
    localparam logic [3:0] KEY_CANCEL  = 4'hB;
    localparam logic [3:0] KEY_SET     = 4'hC;

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        SET     = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : lock_controller_if
// Description : Keypad/password-register side signals of the lock controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface lock_controller_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] pw1, pw2, pw3, pw4, pw5, pw6;
    logic [3:0] ent1, ent2, ent3, ent4, ent5, ent6;
    logic [2:0] digit_cnt;
    logic       pw_load;
    logic       unlock;
    logic       alarm;
    logic [1:0] err_cnt;

    // keypad decoder / password register side
    modport master (
        output key_valid, key_code, pw1, pw2, pw3, pw4, pw5, pw6,
        input  ent1, ent2, ent3, ent4, ent5, ent6,
        input  digit_cnt, pw_load, unlock, alarm, err_cnt
    );

    // controller side
    modport slave (
        input  key_valid, key_code, pw1, pw2, pw3, pw4, pw5, pw6,
        output ent1, ent2, ent3, ent4, ent5, ent6,
        output digit_cnt, pw_load, unlock, alarm, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ============================================================================
// Module      : lock_timer
// Description : Loadable down-counter; done pulses for one cycle when a loaded
//               count of N-1 has run out (N cycles after the load edge).
// Revision    : 1.0 - initial release
// ============================================================================
module lock_timer #(
    parameter int WIDTH = 10
) (
    input  wire logic             clk,
    input  wire logic             clr,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    output logic                  done
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_run;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (load) begin
            r_cnt <= load_val;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign done = r_run && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lock_controller.sv
`default_nettype none
// ============================================================================
// Module      : lock_controller
// Description : Six-digit lock sequencer: entry buffer, password check,
//               password-set strobe and wrong-attempt lockout.
//               Optional macro AUTO_RELOCK_EN adds an OPEN-state idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_controller
    import lock_pkg::*;
#(
    parameter int MAX_ERR     = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int OPEN_CYCLES = 5000
) (
    input  wire logic         clk,
    input  wire logic         clr,
    lock_controller_if.slave  bus
);

    localparam int         c_TMR_MAX  = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
    localparam int         c_TMR_W    = $clog2(c_TMR_MAX);
    localparam logic [c_TMR_W-1:0] c_LOCK_VAL = c_TMR_W'(LOCK_CYCLES - 1);
`ifdef AUTO_RELOCK_EN
    localparam logic [c_TMR_W-1:0] c_OPEN_VAL = c_TMR_W'(OPEN_CYCLES - 1);
`endif
    localparam logic [2:0] c_FULL     = 3'(NUM_DIGITS);
    localparam logic [1:0] c_MAX_ERR  = 2'(MAX_ERR);

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_ent     [NUM_DIGITS];
    logic [3:0]         w_ent_nxt [NUM_DIGITS];
    logic [3:0]         w_pw      [NUM_DIGITS];
    logic [2:0]         r_cnt, w_cnt_nxt;
    logic [1:0]         r_err, w_err_nxt, w_err_inc;
    logic               r_pw_load, w_pw_load_nxt;
    logic               r_unlock, r_alarm;
    logic               w_match, w_digit, w_room;
    logic               w_tmr_load, w_tmr_done;
    logic [c_TMR_W-1:0] w_tmr_val;

    assign w_pw[0] = bus.pw1;
    assign w_pw[1] = bus.pw2;
    assign w_pw[2] = bus.pw3;
    assign w_pw[3] = bus.pw4;
    assign w_pw[4] = bus.pw5;
    assign w_pw[5] = bus.pw6;

    assign w_digit   = bus.key_valid && is_digit(bus.key_code);
    assign w_room    = (r_cnt < c_FULL);
    assign w_err_inc = r_err + 2'd1;

    always_comb begin
        w_match = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_ent[i] != w_pw[i]) w_match = 1'b0;
        end
    end

    lock_timer #(
        .WIDTH (c_TMR_W)
    ) u_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= ENTRY;
            r_cnt     <= '0;
            r_err     <= '0;
            r_pw_load <= 1'b0;
            r_unlock  <= 1'b0;
            r_alarm   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_ent[i] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_pw_load <= w_pw_load_nxt;
            r_unlock  <= (w_state_nxt == OPEN);
            r_alarm   <= (w_state_nxt == LOCKOUT);
            for (int i = 0; i < NUM_DIGITS; i++) r_ent[i] <= w_ent_nxt[i];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;
        w_pw_load_nxt = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_val     = c_LOCK_VAL;
        for (int i = 0; i < NUM_DIGITS; i++) w_ent_nxt[i] = r_ent[i];

        case (r_state)
            ENTRY: begin
                // the cycle after a pw_load strobe only clears the buffer
                if (r_pw_load) begin
                    w_cnt_nxt = '0;
                    for (int i = 0; i < NUM_DIGITS; i++) w_ent_nxt[i] = '0;
                end else if (w_digit && w_room) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (r_cnt == 3'(i)) w_ent_nxt[i] = bus.key_code;
                    end
                    w_cnt_nxt = r_cnt + 3'd1;
                end else if (bus.key_valid && bus.key_code == KEY_CONFIRM && !w_room) begin
                    w_state_nxt = CHECK;
                end else if (bus.key_valid && bus.key_code == KEY_CANCEL) begin
                    w_cnt_nxt = '0;
                    for (int i = 0; i < NUM_DIGITS; i++) w_ent_nxt[i] = '0;
                end
            end

            CHECK: begin
                w_cnt_nxt = '0;
                for (int i = 0; i < NUM_DIGITS; i++) w_ent_nxt[i] = '0;
                if (w_match) begin
                    w_state_nxt = OPEN;
                    w_err_nxt   = '0;
`ifdef AUTO_RELOCK_EN
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_OPEN_VAL;
`endif
                end else if (w_err_inc == c_MAX_ERR) begin
                    w_state_nxt = LOCKOUT;
                    w_err_nxt   = w_err_inc;
                    w_tmr_load  = 1'b1;
                end else begin
                    w_state_nxt = ENTRY;
                    w_err_nxt   = w_err_inc;
                end
            end

            OPEN: begin
                if (bus.key_valid) begin
                    if (bus.key_code == KEY_CONFIRM || bus.key_code == KEY_CANCEL) begin
                        w_state_nxt = ENTRY;
                    end else if (bus.key_code == KEY_SET) begin
                        w_state_nxt = SET;
                        w_cnt_nxt   = '0;
                        for (int i = 0; i < NUM_DIGITS; i++) w_ent_nxt[i] = '0;
                    end
`ifdef AUTO_RELOCK_EN
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_OPEN_VAL;
                end else if (w_tmr_done) begin
                    w_state_nxt = ENTRY;
`endif
                end
            end

            SET: begin
                if (w_digit && w_room) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (r_cnt == 3'(i)) w_ent_nxt[i] = bus.key_code;
                    end
                    w_cnt_nxt = r_cnt + 3'd1;
                end else if (bus.key_valid && bus.key_code == KEY_CONFIRM && !w_room) begin
                    w_pw_load_nxt = 1'b1;
                    w_state_nxt   = ENTRY;
                end else if (bus.key_valid && bus.key_code == KEY_CANCEL) begin
                    w_state_nxt = OPEN;
                    w_cnt_nxt   = '0;
                    for (int i = 0; i < NUM_DIGITS; i++) w_ent_nxt[i] = '0;
`ifdef AUTO_RELOCK_EN
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_OPEN_VAL;
`endif
                end
            end

            LOCKOUT: begin
                if (w_tmr_done) begin
                    w_state_nxt = ENTRY;
                    w_err_nxt   = '0;
                end
            end

            default: w_state_nxt = ENTRY;
        endcase
    end

    assign bus.ent1      = r_ent[0];
    assign bus.ent2      = r_ent[1];
    assign bus.ent3      = r_ent[2];
    assign bus.ent4      = r_ent[3];
    assign bus.ent5      = r_ent[4];
    assign bus.ent6      = r_ent[5];
    assign bus.digit_cnt = r_cnt;
    assign bus.pw_load   = r_pw_load;
    assign bus.unlock    = r_unlock;
    assign bus.alarm     = r_alarm;
    assign bus.err_cnt   = r_err;

endmodule
`default_nettype wire

// File: doc/lock_controller.md
# lock_controller

Sequencing controller for the six-digit electronic lock. It collects keypad digits into a six-slot entry buffer and compares the buffer against the stored six-digit password. It drives the write strobe that loads a new password into the 24-bit password register, and it enforces a wrong-attempt lockout. It sits between the keypad decoder and the password register/display.

## Interface
- MAX_ERR, 3, consecutive wrong attempts that trigger lockout (1..3)
- LOCK_CYCLES, 1000, lockout duration in clk cycles (≥2)
- OPEN_CYCLES, 5000, auto-relock timeout in clk cycles (used only with AUTO_RELOCK_EN)
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- key_valid  in  1  one-cycle strobe qualifying key_code
- key_code  in  4  0–9 digit; 4'hA confirm; 4'hB cancel; 4'hC set-password request; 4'hD–4'hF ignored
- pw1..pw6  in  4 each  stored password digits (pw1 = first digit)
- ent1..ent6  out  4 each  entry buffer (feeds display and password-register data inputs)
- digit_cnt  out  3  digits entered, 0..6
- pw_load  out  1  one-cycle write strobe to password register
- unlock  out  1  lock open
- alarm  out  1  lockout active
- err_cnt  out  2  consecutive wrong attempts

## Operation
- States: ENTRY, CHECK, OPEN, SET, LOCKOUT. Reset state is ENTRY.
- Reset values: all outputs 0, ent1..ent6 = 0.
- Digit handling in ENTRY or SET:
  - A digit with digit_cnt<6 is written to ent[digit_cnt+1], and digit_cnt increments.
  - A digit with digit_cnt==6 is ignored. There is no wrap.
- ENTRY:
  - confirm with digit_cnt==6 → CHECK.
  - confirm with digit_cnt<6 is ignored.
  - cancel clears the buffer and sets digit_cnt=0.
  - 4'hC is ignored.
- CHECK (exactly 1 cycle):
  - All six ent==pw → OPEN and err_cnt=0.
  - Mismatch → err_cnt+1. If the new value ==MAX_ERR → LOCKOUT, else → ENTRY.
  - Either way, the buffer is cleared and digit_cnt=0.
- OPEN:
  - unlock=1.
  - confirm or cancel → ENTRY (relock).
  - 4'hC → SET.
  - Digits are ignored.
- SET:
  - Collects six digits into the buffer.
  - confirm with digit_cnt==6 → pw_load pulse, then → ENTRY.
  - confirm with digit_cnt<6 is ignored.
  - cancel clears the buffer → OPEN.
- LOCKOUT:
  - alarm=1, and all keys are ignored.
  - After LOCK_CYCLES cycles → ENTRY with err_cnt=0.
- Key strobes arriving in CHECK are dropped.
- Only codes defined for the current state have effect.
- clr asserted in any state aborts immediately to ENTRY with reset values. A pending pw_load is never issued.

## Timing
- key_valid sampled at edge N: ent/digit_cnt/state update at edge N. Outputs are registered, so they are visible after N.
- Confirm at edge N → CHECK during cycle N..N+1 → unlock or err_cnt visible after edge N+1. Total latency is 2 edges from the confirm sample.
- SET confirm at edge N → pw_load high for exactly one cycle after N. ent1..ent6 are held stable during that cycle, then cleared at edge N+1.
- LOCKOUT entered at edge M → alarm high for exactly LOCK_CYCLES cycles, then state is ENTRY after edge M+LOCK_CYCLES.
- err_cnt saturates at MAX_ERR and never wraps.

## Configuration
- AUTO_RELOCK_EN defined:
  - In OPEN, a timer reloads on every accepted key.
  - After OPEN_CYCLES cycles with no key_valid → ENTRY with unlock=0.
  - SET has no timeout.
- AUTO_RELOCK_EN undefined: OPEN persists until confirm/cancel/clr. The timer logic for OPEN is absent.

## Structure
- Package lock_pkg holds:
  - the state enum (ENTRY, CHECK, OPEN, SET, LOCKOUT)
  - key-code constants KEY_CONFIRM=4'hA, KEY_CANCEL=4'hB, KEY_SET=4'hC
  - the NUM_DIGITS=6 constant
- Sub-module lock_timer: a loadable down-counter with width $clog2 of the larger cycle parameter, a load/start input and a done pulse. It is shared by LOCKOUT and, when enabled, auto-relock.

## Test plan
- Stored 123456; keys 1,2,3,4,5,6,A → unlock=1 two edges after A; err_cnt=0.
- Stored 123456; enter 123450,A twice → err_cnt=2, unlock=0. Third wrong → alarm=1 for LOCK_CYCLES cycles; digits during alarm leave digit_cnt=0; then ENTRY with err_cnt=0.
- Unlock, then C, 9,8,7,6,5,4,A → one-cycle pw_load with ent1..ent6=9,8,7,6,5,4; unlock=0 afterwards.
- Enter 1,2,3 then A → ignored, digit_cnt=3. Then B → digit_cnt=0. Seven digits → seventh ignored, ent6 keeps the sixth.
- clr pulsed low in SET with digit_cnt=4 → all outputs 0, no pw_load, state ENTRY.
- With AUTO_RELOCK_EN: unlock, then idle OPEN_CYCLES → unlock falls; a key before timeout restarts the count.
